// File: rtl/tdp_ram_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | tdp_ram_arb_pkg -- shared types and round-robin pick helper for the arbiter |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package tdp_ram_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int MAX_IDW  = 3;
  localparam int SUMW     = MAX_IDW + 1;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } rsp_ent_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid_vec & ~skip, scanning ptr, ptr+1, ... modulo nreq.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_NREQ-1:0] valid_vec,
    input logic [MAX_IDW-1:0]  ptr,
    input logic [MAX_NREQ-1:0] skip,
    input int                  nreq
  );
    rr_pick_t        res;
    logic [SUMW-1:0] cand;
    res = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      cand = {1'b0, ptr} + SUMW'(k);
      if (cand >= SUMW'(nreq)) begin
        cand = cand - SUMW'(nreq);
      end
      if ((k < nreq) && !res.found && valid_vec[cand[MAX_IDW-1:0]] && !skip[cand[MAX_IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdp_ram_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | tdp_ram_arbiter_if -- requester handshake, responses and BRAM pin bundle    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface tdp_ram_arbiter_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 6,
  parameter int NREQ  = 4
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*ADDRW-1:0] req_addr;
  logic [NREQ*DATAW-1:0] req_wdata;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ*DATAW-1:0] rsp_rdata;
  logic                  ram_wea;
  logic                  ram_web;
  logic [ADDRW-1:0]      ram_addra;
  logic [ADDRW-1:0]      ram_addrb;
  logic [DATAW-1:0]      ram_dina;
  logic [DATAW-1:0]      ram_dinb;
  logic [DATAW-1:0]      ram_douta;
  logic [DATAW-1:0]      ram_doutb;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_douta, ram_doutb,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, ram_dinb
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_douta, ram_doutb,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_wea, ram_web, ram_addra, ram_addrb, ram_dina, ram_dinb
  );

endinterface

`default_nettype wire

// File: rtl/tdp_ram_arbiter_rsp_pipe.sv
// +----------------------------------------------------------------------------+
// | tdp_ram_rsp_pipe -- per-port {valid,id} delay line and read-data demux      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tdp_ram_rsp_pipe
  import tdp_ram_arb_pkg::*;
#(
  parameter int DATAW  = 32,
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_valid,
  input  logic [MAX_IDW-1:0]    push_id,
  input  logic [DATAW-1:0]      dout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*DATAW-1:0] rsp_rdata
);

  rsp_ent_t stage_q [RD_LAT+1];
  rsp_ent_t stage_d [RD_LAT+1];

  always_comb begin
    stage_d[0] = '{valid: push_valid, id: push_id};
    for (int k = 1; k <= RD_LAT; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // The last stage lines up with dout of the port that took the read.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (stage_q[RD_LAT].valid && (stage_q[RD_LAT].id == MAX_IDW'(i))) begin
        rsp_valid[i]                 = 1'b1;
        rsp_rdata[i*DATAW +: DATAW] = dout;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdp_ram_arbiter.sv
// +----------------------------------------------------------------------------+
// | tdp_ram_arbiter -- round-robin sharing of a true-dual-port BRAM by NREQ     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tdp_ram_arbiter
  import tdp_ram_arb_pkg::*;
#(
  parameter int DATAW  = 32,
  parameter int ADDRW  = 6,
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  tdp_ram_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  rr_pick_t              pick [2];
  logic [1:0]            gnt;
  logic                  hazard;
  logic [NREQ-1:0]       oh_a;
  logic [NREQ-1:0]       oh_b;
  logic [ADDRW-1:0]      addr_a;
  logic [ADDRW-1:0]      addr_b;
  logic [DATAW-1:0]      din_a;
  logic [DATAW-1:0]      din_b;
  logic                  we_a;
  logic                  we_b;
  logic [IDW-1:0]        rr_ptr_q;
  logic [IDW-1:0]        rr_ptr_d;
  logic                  wea_q;
  logic                  wea_d;
  logic                  web_q;
  logic                  web_d;
  logic [ADDRW-1:0]      addra_q;
  logic [ADDRW-1:0]      addra_d;
  logic [ADDRW-1:0]      addrb_q;
  logic [ADDRW-1:0]      addrb_d;
  logic [DATAW-1:0]      dina_q;
  logic [DATAW-1:0]      dina_d;
  logic [DATAW-1:0]      dinb_q;
  logic [DATAW-1:0]      dinb_d;
  logic                  push_a;
  logic                  push_b;
  logic [NREQ-1:0]       rsp_vld_a;
  logic [NREQ-1:0]       rsp_vld_b;
  logic [NREQ*DATAW-1:0] rsp_dat_a;
  logic [NREQ*DATAW-1:0] rsp_dat_b;

  always_comb begin
    pick[PORT_A] = rr_pick(MAX_NREQ'(bus.req_valid), MAX_IDW'(rr_ptr_q), '0, NREQ);
    pick[PORT_B] = rr_pick(MAX_NREQ'(bus.req_valid), MAX_IDW'(rr_ptr_q),
                           MAX_NREQ'(1) << pick[PORT_A].idx, NREQ);
    oh_a   = '0;
    oh_b   = '0;
    addr_a = '0;
    addr_b = '0;
    din_a  = '0;
    din_b  = '0;
    we_a   = 1'b0;
    we_b   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[PORT_A].found && (pick[PORT_A].idx == MAX_IDW'(i))) begin
        oh_a[i] = 1'b1;
        addr_a  = bus.req_addr[i*ADDRW +: ADDRW];
        din_a   = bus.req_wdata[i*DATAW +: DATAW];
        we_a    = bus.req_we[i];
      end
      if (pick[PORT_B].found && (pick[PORT_B].idx == MAX_IDW'(i))) begin
        oh_b[i] = 1'b1;
        addr_b  = bus.req_addr[i*ADDRW +: ADDRW];
        din_b   = bus.req_wdata[i*DATAW +: DATAW];
        we_b    = bus.req_we[i];
      end
    end

    // Only same-address pairs involving a write are ordered; two reads may share.
    hazard        = (addr_a == addr_b) && (we_a || we_b);
    gnt[PORT_A]   = pick[PORT_A].found && rstn;
    gnt[PORT_B]   = pick[PORT_B].found && !hazard && rstn;
    bus.req_ready = (gnt[PORT_A] ? oh_a : '0) | (gnt[PORT_B] ? oh_b : '0);

    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[PORT_A] && (gnt[PORT_B] ? oh_b[i] : oh_a[i])) begin
        rr_ptr_d = (i == NREQ-1) ? '0 : IDW'(i + 1);
      end
    end

    wea_d   = gnt[PORT_A] && we_a;
    web_d   = gnt[PORT_B] && we_b;
    addra_d = gnt[PORT_A] ? addr_a : addra_q;
    addrb_d = gnt[PORT_B] ? addr_b : addrb_q;
    dina_d  = gnt[PORT_A] ? din_a  : dina_q;
    dinb_d  = gnt[PORT_B] ? din_b  : dinb_q;
    push_a  = gnt[PORT_A] && !we_a;
    push_b  = gnt[PORT_B] && !we_b;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      wea_q    <= 1'b0;
      web_q    <= 1'b0;
      addra_q  <= '0;
      addrb_q  <= '0;
      dina_q   <= '0;
      dinb_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wea_q    <= wea_d;
      web_q    <= web_d;
      addra_q  <= addra_d;
      addrb_q  <= addrb_d;
      dina_q   <= dina_d;
      dinb_q   <= dinb_d;
    end
  end

  assign bus.ram_wea   = wea_q;
  assign bus.ram_web   = web_q;
  assign bus.ram_addra = addra_q;
  assign bus.ram_addrb = addrb_q;
  assign bus.ram_dina  = dina_q;
  assign bus.ram_dinb  = dinb_q;

  tdp_ram_rsp_pipe #(
    .DATAW  (DATAW),
    .NREQ   (NREQ),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe_a (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (push_a),
    .push_id    (pick[PORT_A].idx),
    .dout       (bus.ram_douta),
    .rsp_valid  (rsp_vld_a),
    .rsp_rdata  (rsp_dat_a)
  );

  tdp_ram_rsp_pipe #(
    .DATAW  (DATAW),
    .NREQ   (NREQ),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe_b (
    .clk        (clk),
    .rstn       (rstn),
    .push_valid (push_b),
    .push_id    (pick[PORT_B].idx),
    .dout       (bus.ram_doutb),
    .rsp_valid  (rsp_vld_b),
    .rsp_rdata  (rsp_dat_b)
  );

  // A requester is served by at most one port per cycle, so OR-merge is safe.
  assign bus.rsp_valid = rsp_vld_a | rsp_vld_b;
  assign bus.rsp_rdata = rsp_dat_a | rsp_dat_b;

endmodule

`default_nettype wire

// File: tb/tb_tdp_ram_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_tdp_ram_arbiter -- scoreboard bench with BRAM model and grant reference  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_tdp_ram_arbiter;

  localparam int DATAW  = 32;
  localparam int ADDRW  = 6;
  localparam int NREQ   = 4;
  localparam int RD_LAT = 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  tdp_ram_arbiter_if #(.DATAW(DATAW), .ADDRW(ADDRW), .NREQ(NREQ)) bus ();

  tdp_ram_arbiter #(
    .DATAW  (DATAW),
    .ADDRW  (ADDRW),
    .NREQ   (NREQ),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM behavioural model on the DUT pins
  logic [DATAW-1:0] ram [2**ADDRW] = '{default: '0};
  logic [DATAW-1:0] pa  [RD_LAT]   = '{default: '0};
  logic [DATAW-1:0] pb  [RD_LAT]   = '{default: '0};

  always @(posedge clk) begin
    if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
    if (bus.ram_web) ram[bus.ram_addrb] <= bus.ram_dinb;
    pa[0] <= ram[bus.ram_addra];
    pb[0] <= ram[bus.ram_addrb];
    for (int k = 1; k < RD_LAT; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign bus.ram_douta = pa[RD_LAT-1];
  assign bus.ram_doutb = pb[RD_LAT-1];

  // Reference state
  typedef struct packed {
    logic [DATAW-1:0] data;
    int               due;
  } exp_t;

  exp_t             expq [NREQ][$];
  logic [DATAW-1:0] mmem [2**ADDRW] = '{default: '0};
  int               m_ptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ADDRW-1:0] addr_of(input int i);
    return bus.req_addr[i*ADDRW +: ADDRW];
  endfunction

  // Grant reference: list the valid requesters in pointer order, A = first, B = second.
  always @(negedge clk) begin : grant_model
    int              order[$];
    int              a;
    int              b;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    if (!rstn) begin
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) expq[i].delete();
    end else begin
      order.delete();
      for (int k = 0; k < NREQ; k++)
        if (bus.req_valid[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
      a = -1;
      b = -1;
      if (order.size() > 0) a = order[0];
      if (order.size() > 1) begin
        if (!((addr_of(order[1]) == addr_of(a)) && (bus.req_we[a] || bus.req_we[order[1]])))
          b = order[1];
      end
      exp_rdy = '0;
      if (a >= 0) exp_rdy[a] = 1'b1;
      if (b >= 0) exp_rdy[b] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      for (int s = 0; s < 2; s++) begin
        g = (s == 0) ? a : b;
        if (g >= 0) begin
          if (bus.req_we[g]) mmem[addr_of(g)] = bus.req_wdata[g*DATAW +: DATAW];
          else expq[g].push_back('{data: mmem[addr_of(g)], due: cyc + 1 + RD_LAT});
        end
      end
      if (b >= 0)      m_ptr = (b + 1) % NREQ;
      else if (a >= 0) m_ptr = (a + 1) % NREQ;
    end
  end

  always @(negedge clk) begin : rsp_monitor
    exp_t e;
    if (rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        if (expq[i].size() > 0 && expq[i][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL rsp_missing[%0d]: got no response, expected one at cycle %0d", i, expq[i][0].due);
          void'(expq[i].pop_front());
        end
        if (bus.rsp_valid[i]) begin
          if (expq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected[%0d]: got rsp_valid=1 expected 0 (cycle %0d)", i, cyc);
          end else begin
            e = expq[i].pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e.due));
            chk("rsp_rdata", 64'(bus.rsp_rdata[i*DATAW +: DATAW]), 64'(e.data));
          end
        end
      end
    end
  end

  // Driver helpers
  logic [NREQ-1:0] rdy_s;
  int              tick_cyc;

  task automatic set_req(input int i, input logic we, input logic [ADDRW-1:0] addr,
                         input logic [DATAW-1:0] d);
    bus.req_valid[i]                 = 1'b1;
    bus.req_we[i]                    = we;
    bus.req_addr[i*ADDRW +: ADDRW]   = addr;
    bus.req_wdata[i*DATAW +: DATAW]  = d;
  endtask

  task automatic tick();
    @(negedge clk);
    rdy_s    = bus.req_ready;
    tick_cyc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~rdy_s;
  endtask

  task automatic drain();
    int n = 0;
    while (bus.req_valid != '0 && n < 50) begin
      tick();
      n++;
    end
    if (bus.req_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending %b expected 0", bus.req_valid);
      bus.req_valid = '0;
    end
  endtask

  task automatic wait_rsp(input int i, output int at, output logic [DATAW-1:0] d);
    at = -1;
    d  = '0;
    for (int n = 0; n < 20 && at < 0; n++) begin
      @(negedge clk);
      if (bus.rsp_valid[i]) begin
        at = cyc;
        d  = bus.rsp_rdata[i*DATAW +: DATAW];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int               t0;
    int               at;
    logic [DATAW-1:0] d;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Idle after reset
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_we", 64'({bus.ram_wea, bus.ram_web}), 64'd0);
      chk("idle_rsp", 64'(bus.rsp_valid), 64'd0);
      if (k == 0) begin
        chk("reset_addra", 64'(bus.ram_addra), 64'd0);
        chk("reset_addrb", 64'(bus.ram_addrb), 64'd0);
        chk("reset_dina", 64'(bus.ram_dina), 64'd0);
        chk("reset_dinb", 64'(bus.ram_dinb), 64'd0);
      end
    end
    @(posedge clk);
    #1;

    // Preload 16..19 then all four read every cycle: pairs (0,1),(2,3),...
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDRW'(16 + i), $urandom);
    tick();
    chk("preload_grant0", 64'(rdy_s), 64'b0011);
    tick();
    chk("preload_grant1", 64'(rdy_s), 64'b1100);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i]) set_req(i, 1'b0, ADDRW'(16 + i), '0);
      tick();
      chk("rotate", 64'(rdy_s), (k % 2 == 0) ? 64'b0011 : 64'b1100);
    end
    drain();

    // Write then read same address on consecutive cycles
    set_req(0, 1'b1, ADDRW'(5), 32'hDEADBEEF);
    tick();
    t0 = tick_cyc;
    chk("wr_grant", 64'(rdy_s[0]), 64'd1);
    set_req(1, 1'b0, ADDRW'(5), '0);
    tick();
    wait_rsp(1, at, d);
    chk("wr_rd_latency", 64'(at - t0), 64'(2 + RD_LAT));
    chk("wr_rd_data", 64'(d), 64'hDEADBEEF);
    @(posedge clk);
    #1;

    // Hazard: req1 alone leaves the pointer at 2, then req2 write / req3 read addr 9
    set_req(1, 1'b0, ADDRW'(0), '0);
    drain();
    set_req(2, 1'b1, ADDRW'(9), 32'hA5A5_0009);
    set_req(3, 1'b0, ADDRW'(9), '0);
    tick();
    chk("hazard_first", 64'(rdy_s), 64'b0100);
    tick();
    chk("hazard_second", 64'(rdy_s), 64'b1000);
    wait_rsp(3, at, d);
    chk("hazard_data", 64'(d), 64'hA5A5_0009);
    @(posedge clk);
    #1;

    // Two reads to one address both go out
    set_req(0, 1'b1, ADDRW'(3), 32'h1234_5678);
    drain();
    set_req(0, 1'b0, ADDRW'(3), '0);
    set_req(1, 1'b0, ADDRW'(3), '0);
    tick();
    chk("same_rd_grant", 64'(rdy_s), 64'b0011);
    wait_rsp(0, at, d);
    chk("same_rd_both", 64'(bus.rsp_valid[1:0]), 64'b11);
    chk("same_rd_data0", 64'(d), 64'h1234_5678);
    chk("same_rd_data1", 64'(bus.rsp_rdata[DATAW +: DATAW]), 64'h1234_5678);
    @(posedge clk);
    #1;

    // Reset with two reads in flight
    set_req(2, 1'b0, ADDRW'(16), '0);
    set_req(3, 1'b0, ADDRW'(17), '0);
    tick();
    chk("inflight_grant", 64'(rdy_s), 64'b1100);
    rstn = 1'b0;
    #1;
    chk("rst_wea", 64'({bus.ram_wea, bus.ram_web}), 64'd0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("reset_quiet", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    set_req(1, 1'b0, ADDRW'(18), '0);
    set_req(3, 1'b0, ADDRW'(19), '0);
    tick();
    chk("post_reset_grant", 64'(rdy_s), 64'b1010);
    drain();

    // Randomised traffic on a small address window to provoke hazards
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1))
          set_req(i, ($urandom_range(0, 2) == 0), ADDRW'($urandom_range(0, 7)), $urandom);
      tick();
    end
    drain();
    repeat (RD_LAT + 4) @(negedge clk);
    for (int i = 0; i < NREQ; i++) chk("scoreboard_empty", 64'(expq[i].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
